// File: rtl/rst_seq_multi.sv
// -----------------------------------------------------------------------------
// rst_seq_multi
//
// Multi-domain reset sequencer. It holds NDOMAINS active-low domain resets
// after power reset, waits for PLL lock and then releases the domains one at a
// time in index order, STEP_CYCLES apart. One domain (CALIB_DOMAIN) can also be
// gated on DDR calibration. Per-domain soft-reset requests re-sequence the
// requested domain and every domain above it. Loss of PLL lock puts every
// domain back into reset and restarts the sequence.
//
// Optional feature (compile-time macro RST_SEQ_WDOG_EN):
//   defined   - a watchdog forces release of CALIB_DOMAIN after CALIB_TIMEOUT
//               cycles in WAIT_CALIB and sets o_calib_timeout.
//   undefined - WAIT_CALIB waits indefinitely; o_calib_timeout is tied to 0.
//
// Ports:
//   i_clk            single clock (reference oscillator domain)
//   i_rst            asynchronous active-high reset
//   i_pll_lock       PLL locked, asynchronous (synchronised internally)
//   i_calib_done     DDR calibration complete, asynchronous (synchronised)
//   i_sw_rst_req     per-domain soft-reset request, level, synchronous
//   o_nrst           active-low domain resets, registered
//   o_state          FSM state encoding (HOLD=0 .. SW_HOLD=5)
//   o_lock_lost      sticky: PLL lock dropped after a domain was released
//   o_calib_timeout  sticky: calibration watchdog fired
// -----------------------------------------------------------------------------
module rst_seq_multi #(
    parameter int NDOMAINS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STEP_CYCLES   = 16,
    parameter int CALIB_DOMAIN  = 3,
    parameter int SW_RST_CYCLES = 8,
    parameter int CALIB_TIMEOUT = 65536
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pll_lock,
    input  logic                i_calib_done,
    input  logic [NDOMAINS-1:0] i_sw_rst_req,
    output logic [NDOMAINS-1:0] o_nrst,
    output logic [2:0]          o_state,
    output logic                o_lock_lost,
    output logic                o_calib_timeout
);

    typedef enum logic [2:0] {
        S_HOLD       = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_RELEASE    = 3'd2,
        S_WAIT_CALIB = 3'd3,
        S_RUN        = 3'd4,
        S_SW_HOLD    = 3'd5
    } state_t;

    localparam int IDX_W  = $clog2(NDOMAINS);
    localparam int STEP_W = $clog2(STEP_CYCLES) + 1;
    localparam int HOLD_W = $clog2(SW_RST_CYCLES) + 1;

    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SW_RST_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NDOMAINS - 1);

    if (NDOMAINS < 2 || NDOMAINS > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        STEP_CYCLES < 1 || SW_RST_CYCLES < 1 || CALIB_DOMAIN < 0 ||
        CALIB_DOMAIN > NDOMAINS || CALIB_TIMEOUT < 1) begin : g_param_check
        $error("rst_seq_multi: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] calib_sync;
    logic                   lock_s;
    logic                   calib_s;

    state_t              state,    state_d;
    logic [STEP_W-1:0]   step_cnt, step_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic [IDX_W-1:0]    idx,      idx_d;
    logic [NDOMAINS-1:0] nrst,     nrst_d;
    logic                released, released_d;   // any domain released so far
    logic                lock_lost, lock_lost_d;

    logic                release_now;
    logic [IDX_W-1:0]    sw_idx;                 // lowest requested domain
    logic                wdog_expired;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_sync  <= '0;
            calib_sync <= '0;
        end else begin
            lock_sync  <= {lock_sync[SYNC_STAGES-2:0], i_pll_lock};
            calib_sync <= {calib_sync[SYNC_STAGES-2:0], i_calib_done};
        end
    end

    assign lock_s  = lock_sync[SYNC_STAGES-1];
    assign calib_s = calib_sync[SYNC_STAGES-1];

    always_comb begin
        sw_idx = '0;
        for (int i = NDOMAINS - 1; i >= 0; i--) begin
            if (i_sw_rst_req[i]) sw_idx = IDX_W'(i);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        step_cnt_d  = step_cnt;
        hold_cnt_d  = hold_cnt;
        idx_d       = idx;
        nrst_d      = nrst;
        released_d  = released;
        lock_lost_d = lock_lost;
        release_now = 1'b0;

        case (state)
            S_HOLD: begin
                nrst_d  = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                nrst_d = '0;
                if (lock_s) begin
                    step_cnt_d = STEP_LOAD;
                    idx_d      = '0;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (step_cnt != '0) begin
                    step_cnt_d = step_cnt - 1'b1;
                end else if (int'(idx) == CALIB_DOMAIN && !calib_s) begin
                    state_d = S_WAIT_CALIB;
                end else begin
                    release_now = 1'b1;
                end
            end
            S_WAIT_CALIB: begin
                if (calib_s || wdog_expired) release_now = 1'b1;
            end
            S_RUN: begin
                if (|i_sw_rst_req) begin
                    // The requested domain and everything above it go back
                    // into reset; lower domains keep running.
                    for (int i = 0; i < NDOMAINS; i++) begin
                        if (i >= int'(sw_idx)) nrst_d[i] = 1'b0;
                    end
                    idx_d      = sw_idx;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = S_SW_HOLD;
                end
            end
            S_SW_HOLD: begin
                if (hold_cnt != '0) begin
                    hold_cnt_d = hold_cnt - 1'b1;
                end else begin
                    step_cnt_d = STEP_LOAD;
                    state_d    = S_RELEASE;
                end
            end
            default: state_d = S_HOLD;
        endcase

        if (release_now) begin
            nrst_d[idx] = 1'b1;
            released_d  = 1'b1;
            step_cnt_d  = STEP_LOAD;
            if (idx == LAST_IDX) begin
                state_d = S_RUN;
            end else begin
                idx_d   = idx + 1'b1;
                state_d = S_RELEASE;
            end
        end

        // Lock loss overrides everything decided above in the same cycle.
        if (!lock_s && state != S_HOLD && state != S_WAIT_LOCK) begin
            nrst_d  = '0;
            state_d = S_WAIT_LOCK;
            if (released) lock_lost_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_HOLD;
            step_cnt  <= '0;
            hold_cnt  <= '0;
            idx       <= '0;
            nrst      <= '0;
            released  <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_d;
            step_cnt  <= step_cnt_d;
            hold_cnt  <= hold_cnt_d;
            idx       <= idx_d;
            nrst      <= nrst_d;
            released  <= released_d;
            lock_lost <= lock_lost_d;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(CALIB_TIMEOUT) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(CALIB_TIMEOUT - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              calib_timeout;

    // Fires on the CALIB_TIMEOUT-th cycle spent in WAIT_CALIB.
    assign wdog_expired = (state == S_WAIT_CALIB) && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdog_cnt      <= '0;
            calib_timeout <= 1'b0;
        end else begin
            if (state == S_WAIT_CALIB && !wdog_expired) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
            // Only flag a forced release: not when calibration arrived in
            // the same cycle, and not when lock loss pre-empts the release.
            if (wdog_expired && !calib_s && lock_s) calib_timeout <= 1'b1;
        end
    end

    assign o_calib_timeout = calib_timeout;
`else
    assign wdog_expired    = 1'b0;
    assign o_calib_timeout = 1'b0;
`endif

    assign o_nrst      = nrst;
    assign o_state     = state;
    assign o_lock_lost = lock_lost;

endmodule

// File: tb/tb_rst_seq_multi.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_multi
//
// Directed-sequence bench for rst_seq_multi with randomised timing and
// soft-reset patterns. Expected reset masks come from the release-time rules:
// domain j of a sequence starting at domain 'first' is released 'base' +
// (j - first + 1) * STEP edges after the triggering input change.
// -----------------------------------------------------------------------------
module tb_rst_seq_multi;

    localparam int ND   = 4;
    localparam int SS   = 2;
    localparam int STEP = 16;
    localparam int CD   = 3;
    localparam int SW   = 8;
    localparam int TMO  = 100;

    // Edges from the triggering input change to the first counter load.
    localparam int BASE_LOCK = SS + 1;
    localparam int BASE_SW   = 1 + SW;

`ifdef RST_SEQ_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          lock  = 1'b0;
    logic          calib = 1'b0;
    logic [ND-1:0] req   = '0;
    logic [ND-1:0] nrst;
    logic [2:0]    state;
    logic          lost;
    logic          tmo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rst_seq_multi #(
        .NDOMAINS      (ND),
        .SYNC_STAGES   (SS),
        .STEP_CYCLES   (STEP),
        .CALIB_DOMAIN  (CD),
        .SW_RST_CYCLES (SW),
        .CALIB_TIMEOUT (TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pll_lock      (lock),
        .i_calib_done    (calib),
        .i_sw_rst_req    (req),
        .o_nrst          (nrst),
        .o_state         (state),
        .o_lock_lost     (lost),
        .o_calib_timeout (tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Released-domain mask 'm' edges after a sequence trigger. Domains below
    // 'first' are untouched (already running); domains at or above 'limit'
    // are blocked.
    function automatic logic [ND-1:0] seq_mask(input int m, input int base,
                                               input int first, input int limit);
        logic [ND-1:0] r;
        r = '0;
        for (int j = 0; j < ND; j++) begin
            if (j < first) r[j] = 1'b1;
            else if (j < limit && m >= base + (j - first + 1) * STEP) r[j] = 1'b1;
        end
        return r;
    endfunction

    function automatic int lowest_set(input logic [ND-1:0] v);
        for (int j = 0; j < ND; j++) begin
            if (v[j]) return j;
        end
        return ND;
    endfunction

    initial begin
        int            idle;
        int            k;
        int            m_end;
        int            m_drop;
        int            m_w;
        int            extra;
        logic [ND-1:0] pat;
        logic          noisy;

        // Reset values.
        repeat (3) tick();
        check("rst_nrst", nrst, 0);
        check("rst_state", state, 0);
        check("rst_lost", lost, 0);
        check("rst_tmo", tmo, 0);

        rst = 1'b0;
        check("hold_state", state, 0);
        tick();
        check("wait_lock_state", state, 1);
        idle = $urandom_range(2, 12);
        repeat (idle) tick();
        check("prelock_nrst", nrst, 0);
        check("prelock_state", state, 1);

        // Basic sequence with calibration already done.
        lock  = 1'b1;
        calib = 1'b1;
        for (int m = 1; m <= BASE_LOCK + ND * STEP + 2; m++) begin
            tick();
            check("seq_nrst", nrst, seq_mask(m, BASE_LOCK, 0, ND));
        end
        check("seq_state", state, 4);
        check("seq_lost", lost, 0);

        // Soft reset: directed 0110 pulse, then random patterns with random
        // request noise during SW_HOLD/RELEASE, which must be ignored.
        for (int it = 0; it < 4; it++) begin
            pat   = (it == 0) ? 4'b0110 : ND'($urandom_range(1, (1 << ND) - 1));
            noisy = (it != 0);
            k     = lowest_set(pat);
            m_end = BASE_SW + (ND - k) * STEP;
            req   = pat;
            for (int m = 1; m <= m_end + 2; m++) begin
                tick();
                check("sw_nrst", nrst, seq_mask(m, BASE_SW, k, ND));
                if (m == 1) check("sw_state", state, 5);
                if (noisy && m < m_end - 1) req = ND'($urandom_range(0, (1 << ND) - 1));
                else                        req = '0;
            end
            check("sw_end_state", state, 4);
        end

        // Lock loss mid-RELEASE while o_nrst = 0011.
        req    = 4'b0001;
        m_drop = $urandom_range(BASE_SW + 2 * STEP, BASE_SW + 3 * STEP - 4);
        for (int m = 1; m <= m_drop; m++) begin
            tick();
            req = '0;
            check("ll_pre_nrst", nrst, seq_mask(m, BASE_SW, 0, ND));
        end
        check("ll_pre_lost", lost, 0);
        lock = 1'b0;
        for (int e = 1; e <= SS + 1; e++) begin
            tick();
            check("ll_nrst", nrst, (e <= SS) ? 4'b0011 : 4'b0000);
        end
        check("ll_state", state, 1);
        check("ll_lost", lost, 1);
        repeat (3) tick();
        check("ll_wait_state", state, 1);

        // Relock with calibration pending: domain 3 must wait.
        lock  = 1'b1;
        calib = 1'b0;
        extra = $urandom_range(2, 30);
        for (int m = 1; m <= BASE_LOCK + (CD + 1) * STEP + extra; m++) begin
            tick();
            check("gate_nrst", nrst, seq_mask(m, BASE_LOCK, 0, CD));
        end
        check("gate_state", state, 3);
        check("gate_lost", lost, 1);
        check("gate_tmo", tmo, 0);
        calib = 1'b1;
        for (int e = 1; e <= SS + 1; e++) begin
            tick();
            check("calib_nrst", nrst, (e <= SS) ? 4'b0111 : 4'b1111);
        end
        check("calib_state", state, 4);

        // Calibration falling in RUN has no effect.
        calib = 1'b0;
        repeat (SS + 2) tick();
        check("calib_fall_nrst", nrst, 4'hF);
        check("calib_fall_state", state, 4);

        // Full soft reset with calibration low: watchdog forces the release
        // when enabled, otherwise the sequencer keeps waiting.
        req = 4'b0001;
        m_w = BASE_SW + (CD + 1) * STEP;
        for (int m = 1; m <= m_w + TMO; m++) begin
            tick();
            req = '0;
            if (m == 1) check("wd_start_nrst", nrst, 0);
            if (m == m_w) check("wd_enter_state", state, 3);
            if (m == m_w + TMO - 1) check("wd_pre_nrst", nrst, 4'h7);
        end
        check("wd_nrst", nrst, WDOG ? 4'hF : 4'h7);
        check("wd_flag", tmo, WDOG);
        check("wd_state", state, WDOG ? 4 : 3);
        calib = 1'b1;
        repeat (SS + 1) tick();
        check("wd_done_nrst", nrst, 4'hF);
        check("wd_done_state", state, 4);
        check("wd_done_flag", tmo, WDOG);

        // Asynchronous reset while in SW_HOLD, checked before any clock edge.
        pat   = ND'($urandom_range(1, (1 << ND) - 1));
        req   = pat;
        extra = $urandom_range(1, SW - 1);
        for (int m = 1; m <= extra; m++) begin
            tick();
            req = '0;
        end
        check("pre_arst_state", state, 5);
        rst = 1'b1;
        #2;
        check("arst_nrst", nrst, 0);
        check("arst_state", state, 0);
        check("arst_lost", lost, 0);
        check("arst_tmo", tmo, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_arst_state", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_multi.md
Name: rst_seq_multi

Overview:
- Parametrised multi-domain reset sequencer; successor to the single-stage reset logic inside the PRCI block.
- Holds N reset domains after power reset, waits for PLL lock, then releases domains one at a time in index order with a programmable gap.
- Can optionally gate one domain on DDR calibration, and handles per-domain soft-reset requests (e.g. debug dmreset) and PLL lock loss.
- Sits between the PLL/DDR controller status outputs and the SoC nrst inputs, in the board top level.

Parameters:
- NDOMAINS, 4: number of reset domains (2..8); index 0 released first.
- SYNC_STAGES, 2: synchroniser depth for i_pll_lock and i_calib_done (2..4).
- STEP_CYCLES, 16: clocks between consecutive domain releases (>=1).
- CALIB_DOMAIN, 3: domain index whose release additionally requires calibration done; value NDOMAINS disables gating.
- SW_RST_CYCLES, 8: clocks a soft-reset domain is held (>=1).
- CALIB_TIMEOUT, 65536: watchdog limit, used only with RST_SEQ_WDOG_EN.

Ports:
- i_clk  in  1  single clock (reference oscillator domain).
- i_rst  in  1  asynchronous, active-high reset.
- i_pll_lock  in  1  PLL locked, asynchronous.
- i_calib_done  in  1  DDR calibration complete, asynchronous.
- i_sw_rst_req  in  NDOMAINS  per-domain soft-reset request, level-sampled, synchronous to i_clk.
- o_nrst  out  NDOMAINS  active-low domain resets, registered.
- o_state  out  3  FSM state encoding.
- o_lock_lost  out  1  sticky: PLL lock dropped after first release.
- o_calib_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset is asynchronous, active-high on i_rst, and there is one clock. During reset: o_nrst = all 0, o_state = HOLD(0), o_lock_lost = 0, o_calib_timeout = 0, and all counters and synchronisers = 0.
- i_pll_lock and i_calib_done pass through SYNC_STAGES flops. All decisions below use the synchronised values (lock_s, calib_s).
- HOLD(0): one cycle after reset deasserts, go to WAIT_LOCK.
- WAIT_LOCK(1):
  - o_nrst = 0.
  - When lock_s = 1, load step counter = STEP_CYCLES-1, set idx = 0, go to RELEASE.
- RELEASE(2):
  - Counter decrements each cycle.
  - At counter = 0, deassert o_nrst[idx] on the next edge, increment idx and reload the counter.
  - If idx == CALIB_DOMAIN and calib_s = 0, go to WAIT_CALIB instead of releasing.
  - After idx NDOMAINS-1 is released, go to RUN.
  - Release of domain k occurs exactly SYNC_STAGES + 1 + (k+1)*STEP_CYCLES cycles after i_pll_lock rises, when calibration gating does not apply.
- WAIT_CALIB(3):
  - Hold. When calib_s = 1, release CALIB_DOMAIN on the next edge, reload the counter and return to RELEASE.
- RUN(4):
  - All o_nrst = 1.
  - Any bit of i_sw_rst_req set: pick the lowest set index k. Drive o_nrst[k..NDOMAINS-1] = 0, load the hold counter = SW_RST_CYCLES-1, go to SW_HOLD.
- SW_HOLD(5):
  - Count down.
  - At 0: idx = k, reload the step counter, go to RELEASE; domains above k re-sequence in order.
  - Requests arriving during SW_HOLD or RELEASE are ignored.
- Lock loss: lock_s = 0 in any state other than HOLD/WAIT_LOCK.
  - Next edge: o_nrst = all 0, state = WAIT_LOCK.
  - Set o_lock_lost if at least one domain had been released.
  - Lock loss takes priority over soft-reset and calibration events in the same cycle.
- i_calib_done falling after CALIB_DOMAIN is released has no effect.
- o_lock_lost and o_calib_timeout clear only on i_rst.
- Counters are $clog2(max)+1 bits wide and never wrap; each is loaded and decremented only in its owning state.

Optional Feature:
- Macro: RST_SEQ_WDOG_EN.
- Defined:
  - A watchdog counter runs in WAIT_CALIB.
  - On reaching CALIB_TIMEOUT cycles, CALIB_DOMAIN is released regardless, o_calib_timeout is set and sequencing continues.
  - The counter clears on leaving WAIT_CALIB.
- Undefined:
  - WAIT_CALIB waits indefinitely.
  - o_calib_timeout is tied to 0 and no watchdog logic is present.

Test Plan:
- Basic sequence (defaults): i_rst pulse, then i_pll_lock = 1, i_calib_done = 1 from t0 -> o_nrst steps 0001, 0011, 0111, 1111; domain0 releases at lock edge + 19 cycles, each later step +16; o_state ends at 4.
- Calibration gating: i_calib_done held 0 -> o_nrst stays 0111 and o_state = 3; raise i_calib_done -> o_nrst = 1111 SYNC_STAGES+1 cycles later.
- Soft reset: in RUN, pulse i_sw_rst_req = 4'b0110 for 1 cycle -> o_nrst = 0001 for 8 cycles; domain1 releases 16 cycles later, domain2 16 cycles after that, then domain3.
- Lock loss: drop i_pll_lock mid-RELEASE with o_nrst = 0011 -> o_nrst = 0000 within SYNC_STAGES+1 cycles, o_lock_lost = 1, o_state = 1; relock -> full resequence, o_lock_lost stays 1.
- Async reset mid-operation: assert i_rst in SW_HOLD -> all outputs reach reset values immediately without a clock edge.
- With RST_SEQ_WDOG_EN and CALIB_TIMEOUT = 100: i_calib_done = 0 -> domain3 released 100 cycles after entering WAIT_CALIB, o_calib_timeout = 1.
